// File: rtl/drop_controller_if.sv
// Bus between the column-select logic, the drop controller, the board RAM write port
// and the turn tracker. The master drives requests; the slave is the drop controller.
interface drop_controller_if;
  logic       drop_req;
  logic [2:0] drop_col;
  logic [1:0] player;
  logic       busy;
  logic       wr_en;
  logic [2:0] wr_col;
  logic [2:0] wr_row;
  logic [1:0] wr_data;
  logic       turn_advance;
  logic       reject;
  logic       board_full;

  modport master (
    output drop_req, drop_col, player,
    input  busy, wr_en, wr_col, wr_row, wr_data, turn_advance, reject, board_full
  );

  modport slave (
    input  drop_req, drop_col, player,
    output busy, wr_en, wr_col, wr_row, wr_data, turn_advance, reject, board_full
  );
endinterface

// File: rtl/drop_controller.sv
// Connect-4 drop controller: validates a column drop against per-column fill heights,
// writes the piece through the board RAM write port and pulses turn_advance on landing.
// Optional falling-piece animation is enabled by defining DROP_ANIM_EN.
module drop_controller #(
  parameter int unsigned COLS       = 7,
  parameter int unsigned ROWS       = 6,
  parameter int unsigned ANIM_TICKS = 4
) (
  input logic              clk,
  input logic              reset,
  drop_controller_if.slave bus
);

  // Parameter sanity checks at elaboration.
  if (COLS < 1 || COLS > 8 || ROWS < 1 || ROWS > 7 || ANIM_TICKS < 1) begin : g_param_check
    $error("drop_controller: parameter out of range");
  end

  // CHECK is the first post-accept cycle; it carries the write (or reject) itself.
  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAdvance,
    StFallSet,
    StFallWait,
    StFallClr
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic [1:0]  player_q, player_d;
  logic [2:0]  height_q [COLS];
  logic [2:0]  height_d [COLS];
  logic [2:0]  wr_col_q, wr_row_q;
  logic [1:0]  wr_data_q;

  logic        accept;
  logic        col_ok;
  logic [2:0]  cur_height;
  logic        drop_ok;
  logic        land;
  logic        wr_en;
  logic [2:0]  cur_row;
  logic [1:0]  cur_data;
  logic        full;

`ifdef DROP_ANIM_EN
  localparam int unsigned TickW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  logic [2:0]       row_q, row_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             wait_done;
  assign wait_done = (tick_q == TickW'(ANIM_TICKS - 1));
`endif

  assign accept = (state_q == StIdle) && bus.drop_req;
  assign col_ok = (32'(col_q) < COLS);

  // Height of the latched column; out-of-range columns read 0 but are rejected anyway.
  always_comb begin
    cur_height = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == 3'(c)) cur_height = height_q[c];
    end
  end

  assign drop_ok = col_ok && (cur_height != 3'(ROWS)) &&
                   ((player_q == 2'b01) || (player_q == 2'b10));

  // Board is full when every column has reached ROWS.
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (height_q[c] != 3'(ROWS)) full = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.drop_req) state_d = StCheck;
`ifdef DROP_ANIM_EN
      StCheck:   state_d = drop_ok ? StFallSet : StIdle;
      StFallSet: state_d = StFallWait;
      StFallWait: begin
        if (wait_done) state_d = (row_q > cur_height) ? StFallClr : StAdvance;
      end
      StFallClr: state_d = StFallSet;
`else
      StCheck:   state_d = drop_ok ? StAdvance : StIdle;
`endif
      StAdvance: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.busy         = (state_q != StIdle);
    bus.reject       = (state_q == StCheck) && !drop_ok;
    bus.turn_advance = (state_q == StAdvance);
`ifdef DROP_ANIM_EN
    wr_en    = (state_q == StFallSet) || (state_q == StFallClr);
    cur_row  = row_q;
    cur_data = (state_q == StFallClr) ? 2'b00 : player_q;
    land     = (state_q == StFallWait) && wait_done && (row_q == cur_height);
`else
    wr_en    = (state_q == StCheck) && drop_ok;
    cur_row  = cur_height;
    cur_data = player_q;
    land     = wr_en;
`endif
    bus.wr_en   = wr_en;
    // Address/data hold their last written values between strobes.
    bus.wr_col  = wr_en ? col_q    : wr_col_q;
    bus.wr_row  = wr_en ? cur_row  : wr_row_q;
    bus.wr_data = wr_en ? cur_data : wr_data_q;
    bus.board_full = full;
  end

  // Request latch and height update.
  always_comb begin
    col_d    = accept ? bus.drop_col : col_q;
    player_d = accept ? bus.player   : player_q;
    for (int c = 0; c < COLS; c++) begin
      height_d[c] = height_q[c];
      if (land && (col_q == 3'(c))) height_d[c] = height_q[c] + 3'd1;
    end
  end

  // Datapath registers; reset aborts any drop in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      player_q  <= '0;
      wr_col_q  <= '0;
      wr_row_q  <= '0;
      wr_data_q <= '0;
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
    end else begin
      col_q    <= col_d;
      player_q <= player_d;
      for (int c = 0; c < COLS; c++) height_q[c] <= height_d[c];
      if (wr_en) begin
        wr_col_q  <= col_q;
        wr_row_q  <= cur_row;
        wr_data_q <= cur_data;
      end
    end
  end

`ifdef DROP_ANIM_EN
  // Falling row starts at the top and steps down after each clear; tick counts the hold.
  always_comb begin
    row_d  = row_q;
    tick_d = '0;
    case (state_q)
      StCheck:    row_d = 3'(ROWS - 1);
      StFallClr:  row_d = row_q - 3'd1;
      StFallWait: tick_d = tick_q + TickW'(1);
      default:    ;
    endcase
  end

  // Animation registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= '0;
      tick_q <= '0;
    end else begin
      row_q  <= row_d;
      tick_q <= tick_d;
    end
  end
`endif

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller (default parameters). With DROP_ANIM_EN defined only
// the animation sequence is exercised.
module tb_drop_controller;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  drop_controller_if bus_if ();

  drop_controller #(
    .COLS      (7),
    .ROWS      (6),
    .ANIM_TICKS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.drop_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus_if.busy), 0);
    check({tag, "_wr_en"}, 32'(bus_if.wr_en), 0);
    check({tag, "_turn_adv"}, 32'(bus_if.turn_advance), 0);
    check({tag, "_reject"}, 32'(bus_if.reject), 0);
  endtask

`ifndef DROP_ANIM_EN
  // One request in cycle N; checks N+1, N+2 and (on success) N+3.
  task automatic do_drop(input string tag, input logic [2:0] col, input logic [1:0] ply,
                         input bit ok, input int row);
    check({tag, "_n_busy"}, 32'(bus_if.busy), 0);
    bus_if.drop_req = 1'b1;
    bus_if.drop_col = col;
    bus_if.player   = ply;
    step();
    bus_if.drop_req = 1'b0;
    check({tag, "_n1_busy"}, 32'(bus_if.busy), 1);
    check({tag, "_n1_wr_en"}, 32'(bus_if.wr_en), 32'(ok));
    check({tag, "_n1_reject"}, 32'(bus_if.reject), 32'(!ok));
    check({tag, "_n1_turn_adv"}, 32'(bus_if.turn_advance), 0);
    if (ok) begin
      check({tag, "_wr_col"}, 32'(bus_if.wr_col), 32'(col));
      check({tag, "_wr_row"}, 32'(bus_if.wr_row), row);
      check({tag, "_wr_data"}, 32'(bus_if.wr_data), 32'(ply));
    end
    step();
    if (ok) begin
      check({tag, "_n2_turn_adv"}, 32'(bus_if.turn_advance), 1);
      check({tag, "_n2_busy"}, 32'(bus_if.busy), 1);
      check({tag, "_n2_wr_en"}, 32'(bus_if.wr_en), 0);
      step();
    end
    check_idle_outputs({tag, "_end"});
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus_if.drop_req = 1'b0;
    bus_if.drop_col = '0;
    bus_if.player   = 2'b01;
    do_reset();

    check_idle_outputs("rst");
    check("rst_wr_col", 32'(bus_if.wr_col), 0);
    check("rst_wr_row", 32'(bus_if.wr_row), 0);
    check("rst_wr_data", 32'(bus_if.wr_data), 0);
    check("rst_full", 32'(bus_if.board_full), 0);

`ifndef DROP_ANIM_EN
    do_drop("first", 3'd3, 2'b01, 1'b1, 0);

    // Fill column 0 with alternating players, then overflow it.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      do_drop("col0", 3'd0, (r % 2 == 0) ? 2'b01 : 2'b10, 1'b1, r);
    end
    do_drop("col0_over", 3'd0, 2'b01, 1'b0, 0);

    // Invalid column and invalid player leave heights alone.
    do_drop("bad_col", 3'd7, 2'b01, 1'b0, 0);
    do_drop("bad_ply", 3'd2, 2'b00, 1'b0, 0);
    do_drop("col2_ok", 3'd2, 2'b10, 1'b1, 0);

    // Fill the whole board.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        if (c == 6 && r == 5) check("full_before", 32'(bus_if.board_full), 0);
        do_drop("fill", 3'(c), ((c * 6 + r) % 2 == 0) ? 2'b01 : 2'b10, 1'b1, r);
      end
    end
    check("full_after", 32'(bus_if.board_full), 1);
    do_drop("full_rej", 3'd4, 2'b01, 1'b0, 0);
    check("full_still", 32'(bus_if.board_full), 1);
    do_reset();
    check("full_cleared", 32'(bus_if.board_full), 0);
    do_drop("after_full", 3'd0, 2'b01, 1'b1, 0);

    // Reset during the write cycle aborts the drop.
    bus_if.drop_req = 1'b1;
    bus_if.drop_col = 3'd5;
    bus_if.player   = 2'b10;
    step();
    bus_if.drop_req = 1'b0;
    check("abort_n1_wr_en", 32'(bus_if.wr_en), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("abort");
    check("abort_wr_col", 32'(bus_if.wr_col), 0);
    check("abort_wr_row", 32'(bus_if.wr_row), 0);
    check("abort_wr_data", 32'(bus_if.wr_data), 0);
    step();
    check("abort_no_adv", 32'(bus_if.turn_advance), 0);
    do_drop("abort_again", 3'd5, 2'b01, 1'b1, 0);
`else
    // Animated drop into empty column 5.
    bus_if.drop_req = 1'b1;
    bus_if.drop_col = 3'd5;
    bus_if.player   = 2'b01;
    step();
    bus_if.drop_req = 1'b0;
    check("anim_check_busy", 32'(bus_if.busy), 1);
    check("anim_check_wr", 32'(bus_if.wr_en), 0);
    for (int r = 5; r >= 0; r--) begin
      step();
      check("anim_set_wr", 32'(bus_if.wr_en), 1);
      check("anim_set_row", 32'(bus_if.wr_row), r);
      check("anim_set_col", 32'(bus_if.wr_col), 5);
      check("anim_set_data", 32'(bus_if.wr_data), 1);
      for (int t = 0; t < 4; t++) begin
        step();
        check("anim_wait_wr", 32'(bus_if.wr_en), 0);
        check("anim_wait_busy", 32'(bus_if.busy), 1);
        check("anim_wait_adv", 32'(bus_if.turn_advance), 0);
      end
      if (r > 0) begin
        step();
        check("anim_clr_wr", 32'(bus_if.wr_en), 1);
        check("anim_clr_row", 32'(bus_if.wr_row), r);
        check("anim_clr_data", 32'(bus_if.wr_data), 0);
      end
    end
    step();
    check("anim_adv", 32'(bus_if.turn_advance), 1);
    step();
    check_idle_outputs("anim_end");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
